// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: divider state encoding and default operand width.
package arith_pkg;

    localparam int DIV_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle between the arithmetic unit and the sequential divider.
interface seq_divider_if
    import arith_pkg::*;
#(
    parameter int N = DIV_WIDTH
);

    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         ready;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  ready, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output ready, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/div_sub_step.sv
// One restoring-division step: trial subtract of the divisor from the shifted partial remainder.
module div_sub_step
    import arith_pkg::*;
#(
    parameter int N = DIV_WIDTH
) (
    input  logic [N:0]   partial,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] rem_next,
    output logic         q_bit
);

    logic [N:0] trial;

    // The partial remainder is always below twice the divisor, so N+1 bits hold
    // the difference and its MSB is the borrow.
    assign trial    = partial - {1'b0, divisor};
    assign q_bit    = ~trial[N];
    assign rem_next = trial[N] ? partial[N-1:0] : trial[N-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock.
// Define DIVIDER_SIGNED_EN for two's-complement operands (magnitude core plus sign fix-up).
module seq_divider
    import arith_pkg::*;
#(
    parameter int N     = DIV_WIDTH,
    parameter int CNT_W = 3
) (
    input logic          clk,
    input logic          rst,
    seq_divider_if.slave bus
);

    div_state_t state, state_next;
    logic              accept;
    logic              zero_div;
    logic [CNT_W-1:0]  cnt;
    logic [N-1:0]      rem;
    logic [N-1:0]      dvd;
    logic [N-1:0]      dsr;
    logic [N-1:0]      quotient_r;
    logic [N-1:0]      remainder_r;
    logic              dz_r;
    logic [N-1:0]      mag_dividend;
    logic [N-1:0]      mag_divisor;
    logic [N-1:0]      rem_next;
    logic              q_bit;
    logic [N-1:0]      q_raw;
    logic [N-1:0]      q_final;
    logic [N-1:0]      r_final;

    assign zero_div = (bus.divisor == '0);

    div_sub_step #(.N(N)) u_step (
        .partial  ({rem, dvd[N-1]}),
        .divisor  (dsr),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    // Quotient bits are shifted into the vacated low end of the dividend register.
    assign q_raw = {dvd[N-2:0], q_bit};

`ifdef DIVIDER_SIGNED_EN
    logic neg_q;
    logic neg_r;

    assign mag_dividend = bus.dividend[N-1] ? -bus.dividend : bus.dividend;
    assign mag_divisor  = bus.divisor[N-1]  ? -bus.divisor  : bus.divisor;
    assign q_final      = neg_q ? -q_raw    : q_raw;
    assign r_final      = neg_r ? -rem_next : rem_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (accept) begin
            neg_q <= bus.dividend[N-1] ^ bus.divisor[N-1];
            neg_r <= bus.dividend[N-1];
        end
    end
`else
    assign mag_dividend = bus.dividend;
    assign mag_divisor  = bus.divisor;
    assign q_final      = q_raw;
    assign r_final      = rem_next;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = zero_div ? DONE : BUSY;
                end else if (state == DONE) begin
                    state_next = IDLE;
                end
            end
            BUSY: begin
                if (cnt == CNT_W'(1)) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Results change only when the FSM enters DONE; BUSY leaves the previous ones visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            rem         <= '0;
            dvd         <= '0;
            dsr         <= '0;
            quotient_r  <= '0;
            remainder_r <= '0;
            dz_r        <= 1'b0;
        end else if (accept) begin
            if (zero_div) begin
                quotient_r  <= '1;
                remainder_r <= bus.dividend;
                dz_r        <= 1'b1;
            end else begin
                dvd <= mag_dividend;
                dsr <= mag_divisor;
                rem <= '0;
                cnt <= CNT_W'(N);
            end
        end else if (state == BUSY) begin
            dvd <= q_raw;
            rem <= rem_next;
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
                quotient_r  <= q_final;
                remainder_r <= r_final;
                dz_r        <= 1'b0;
            end
        end
    end

    assign bus.ready       = (state != BUSY);
    assign bus.done        = (state == DONE);
    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.div_by_zero = dz_r;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and exhaustive checks of seq_divider at N=4 (unsigned, or signed with DIVIDER_SIGNED_EN).
module tb_seq_divider;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    seq_divider_if #(.N(4)) bus ();

    seq_divider #(.N(4), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

`ifdef DIVIDER_SIGNED_EN
    localparam logic [3:0] T1_Q = 4'hF, T1_R = 4'h0;
    localparam logic [3:0] T3_Q = 4'hF, T3_R = 4'h0;
    localparam logic [3:0] T4_Q = 4'h0, T4_R = 4'hE;
`else
    localparam logic [3:0] T1_Q = 4'd4, T1_R = 4'd1;
    localparam logic [3:0] T3_Q = 4'd0, T3_R = 4'd7;
    localparam logic [3:0] T4_Q = 4'd4, T4_R = 4'd2;
`endif

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Present one operand pair for exactly one sampling edge, then scramble the inputs.
    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] d);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = d;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.dividend = 4'hA;
        bus.divisor  = 4'h5;
    endtask

    task automatic waitDone(output int cycles);
        cycles = 0;
        while (bus.done !== 1'b1 && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic countDones(input int n, output int seen);
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) seen++;
        end
    endtask

    function automatic void refDiv(input logic [3:0] a, input logic [3:0] d,
                                   output logic [3:0] q, output logic [3:0] r, output logic dz);
`ifdef DIVIDER_SIGNED_EN
        int sa;
        int sd;
        sa = $signed(a);
        sd = $signed(d);
        if (d == 4'd0) begin
            q = 4'hF; r = a; dz = 1'b1;
        end else begin
            q = 4'(sa / sd); r = 4'(sa % sd); dz = 1'b0;
        end
`else
        if (d == 4'd0) begin
            q = 4'hF; r = a; dz = 1'b1;
        end else begin
            q = a / d; r = a % d; dz = 1'b0;
        end
`endif
    endfunction

    initial begin
        int cyc;
        int seen;
        logic [3:0] eq, er;
        logic       edz;
        total        = 0;
        bad          = 0;
        bus.start    = 1'b0;
        bus.dividend = 4'd0;
        bus.divisor  = 4'd0;
        rst          = 1'b1;
        #2;
        checkOutput("reset quotient", bus.quotient, 4'd0);
        checkOutput("reset remainder", bus.remainder, 4'd0);
        checkOutput("reset dz", bus.div_by_zero, 1'b0);
        checkOutput("reset done", bus.done, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("reset ready", bus.ready, 1'b1);

        // 13/3: N+1 edges to done, one-cycle done pulse, results held afterwards
        applyStimulus(4'd13, 4'd3);
        checkOutput("t1 busy ready", bus.ready, 1'b0);
        waitDone(cyc);
        checkOutput("t1 latency", cyc, 4);
        checkOutput("t1 q", bus.quotient, T1_Q);
        checkOutput("t1 r", bus.remainder, T1_R);
        checkOutput("t1 dz", bus.div_by_zero, 1'b0);
        checkOutput("t1 ready", bus.ready, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("t1 done pulse", bus.done, 1'b0);
        checkOutput("t1 q held", bus.quotient, T1_Q);

        // 9/0 then 15/1 issued back-to-back from DONE
        applyStimulus(4'd9, 4'd0);
        waitDone(cyc);
        checkOutput("t2 dz latency", cyc, 0);
        checkOutput("t2 dz q", bus.quotient, 4'hF);
        checkOutput("t2 dz r", bus.remainder, 4'd9);
        checkOutput("t2 dz flag", bus.div_by_zero, 1'b1);
        applyStimulus(4'd15, 4'd1);
        checkOutput("t2 busy q held", bus.quotient, 4'hF);
        checkOutput("t2 busy dz held", bus.div_by_zero, 1'b1);
        waitDone(cyc);
        checkOutput("t2 b2b latency", cyc, 4);
        checkOutput("t2 b2b q", bus.quotient, 4'hF);
        checkOutput("t2 b2b r", bus.remainder, 4'd0);
        checkOutput("t2 b2b dz", bus.div_by_zero, 1'b0);

        // 7/9 with a stray 8/2 start while BUSY
        applyStimulus(4'd7, 4'd9);
        applyStimulus(4'd8, 4'd2);
        waitDone(cyc);
        checkOutput("t3 latency", cyc, 3);
        checkOutput("t3 q", bus.quotient, T3_Q);
        checkOutput("t3 r", bus.remainder, T3_R);
        countDones(6, seen);
        checkOutput("t3 single done", seen, 0);

        // reset during the second BUSY cycle of 14/3 aborts it
        applyStimulus(4'd14, 4'd3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("t4 rst q", bus.quotient, 4'd0);
        checkOutput("t4 rst r", bus.remainder, 4'd0);
        checkOutput("t4 rst dz", bus.div_by_zero, 1'b0);
        checkOutput("t4 rst done", bus.done, 1'b0);
        checkOutput("t4 rst ready", bus.ready, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        countDones(6, seen);
        checkOutput("t4 no done after abort", seen, 0);
        applyStimulus(4'd14, 4'd3);
        waitDone(cyc);
        checkOutput("t4 latency", cyc, 4);
        checkOutput("t4 q", bus.quotient, T4_Q);
        checkOutput("t4 r", bus.remainder, T4_R);

`ifdef DIVIDER_SIGNED_EN
        applyStimulus(4'b1001, 4'd2);
        waitDone(cyc);
        checkOutput("t5 -7/2 q", bus.quotient, 4'b1101);
        checkOutput("t5 -7/2 r", bus.remainder, 4'b1111);
        applyStimulus(4'd7, 4'b1110);
        waitDone(cyc);
        checkOutput("t5 7/-2 q", bus.quotient, 4'b1101);
        checkOutput("t5 7/-2 r", bus.remainder, 4'b0001);
        applyStimulus(4'b1000, 4'b1111);
        waitDone(cyc);
        checkOutput("t5 -8/-1 q", bus.quotient, 4'b1000);
        checkOutput("t5 -8/-1 r", bus.remainder, 4'b0000);
        checkOutput("t5 -8/-1 dz", bus.div_by_zero, 1'b0);
`endif

        // every operand pair against the reference model
        for (int a = 0; a < 16; a++) begin
            for (int d = 0; d < 16; d++) begin
                refDiv(4'(a), 4'(d), eq, er, edz);
                applyStimulus(4'(a), 4'(d));
                waitDone(cyc);
                checkOutput($sformatf("sweep lat %0d/%0d", a, d), cyc, (d == 0) ? 0 : 4);
                checkOutput($sformatf("sweep q %0d/%0d", a, d), bus.quotient, eq);
                checkOutput($sformatf("sweep r %0d/%0d", a, d), bus.remainder, er);
                checkOutput($sformatf("sweep dz %0d/%0d", a, d), bus.div_by_zero, edz);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout expected=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
